// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   NUM_LANES   : byte lanes per memory word
//   REQ_CORE/LOAD: requester ids (core LSU = 0, program/debug loader = 1)
//   IDLE/ACCESS : arbiter FSM state encodings
//   merge_lanes : byte-enable merge of store data over the current memory word
package dmem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  // Lane k takes the store byte when be[k] is set, else keeps the memory byte.
  function automatic logic [8*NUM_LANES-1:0] merge_lanes(
    input logic [8*NUM_LANES-1:0] wdata,
    input logic [8*NUM_LANES-1:0] rdata,
    input logic [NUM_LANES-1:0]   be
  );
    logic [8*NUM_LANES-1:0] m;
    m = rdata;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (be[k]) m[8*k +: 8] = wdata[8*k +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Combinational winner selection for the two requesters.
//   valid      : request-present bits {req1, req0}
//   last_grant : requester granted most recently
//   lock_vld   : a burst lock is held by lock_id
//   hold_cnt   : consecutive grants to last_grant
//   grant      : some requester wins this cycle
//   winner     : id of the winning requester (meaningful when grant=1)
module dmem_rr_picker
  import dmem_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HW       = 4
) (
  input  logic [1:0]    valid,
  input  logic          last_grant,
  input  logic          lock_vld,
  input  logic          lock_id,
  input  logic [HW-1:0] hold_cnt,
  output logic          grant,
  output logic          winner
);

  always_comb begin
    grant  = |valid;
    winner = REQ_CORE;
    if (lock_vld && valid[lock_id]) begin
      // Owner keeps the port until it has used up its hold budget while the
      // other side is waiting; then the other side is forced in.
      if (hold_cnt == HW'(MAX_HOLD) && valid[~lock_id]) winner = ~lock_id;
      else                                                winner = lock_id;
    end else if (&valid) begin
      winner = ~last_grant;
    end else begin
      winner = valid[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port word-wide data memory.
// An accepted request is captured in IDLE, performs its memory access in the
// following ACCESS cycle (read-merge-write for partial stores) and returns the
// pre-write word as a one-cycle response pulse one cycle after that.
//   req*_valid/ready/we/be/addr/wdata/lock : requester handshakes
//   rsp*_valid/rdata                        : registered responses
//   mem_memw/address/data_write/data_read   : data memory port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [3:0]        req0_be,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [3:0]        req1_be,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_memw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  input  logic [DATA_W-1:0] mem_data_read
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [0:0]               state_q, state_d;
  logic                     id_q, id_d;
  logic                     we_q, we_d;
  logic [NUM_LANES-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     lock_vld_q, lock_vld_d;
  logic                     lock_id_q, lock_id_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic                     last_q, last_d;
  logic [1:0]               rsp_valid_q, rsp_valid_d;
  logic [1:0][DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [1:0] valid;
  logic       grant, winner, accept, in_access;

  assign valid     = {req1_valid, req0_valid};
  assign in_access = (state_q == ACCESS);

  dmem_rr_picker #(.MAX_HOLD(MAX_HOLD), .HW(HW)) u_picker (
    .valid      (valid),
    .last_grant (last_q),
    .lock_vld   (lock_vld_q),
    .lock_id    (lock_id_q),
    .hold_cnt   (hold_q),
    .grant      (grant),
    .winner     (winner)
  );

  assign accept     = (state_q == IDLE) && grant;
  assign req0_ready = accept && (winner == REQ_CORE);
  assign req1_ready = accept && (winner == REQ_LOAD);

  assign mem_memw       = in_access && we_q && (|be_q);
  assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_data_write = in_access ? merge_lanes(wdata_q, mem_data_read, be_q) : wdata_q;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_rdata = rsp_rdata_q[1];

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lock_vld_d  = lock_vld_q;
    lock_id_d   = lock_id_q;
    hold_d      = hold_q;
    last_d      = last_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;

    if (state_q == IDLE) begin
      // An owner that walks away gives up its lock.
      if (lock_vld_q && !valid[lock_id_q]) lock_vld_d = 1'b0;
      if (grant) begin
        state_d = ACCESS;
        id_d    = winner;
        we_d    = winner ? req1_we    : req0_we;
        be_d    = winner ? req1_be    : req0_be;
        addr_d  = winner ? req1_addr  : req0_addr;
        wdata_d = winner ? req1_wdata : req0_wdata;
        // The accepted transfer's lock bit decides the new owner; this also
        // covers release by the owner and clearing on a forced switch.
        lock_vld_d = winner ? req1_lock : req0_lock;
        lock_id_d  = winner;
        if (winner == last_q)
          hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
        else
          hold_d = HW'(1);
        last_d = winner;
      end
    end else begin
      state_d              = IDLE;
      rsp_valid_d[id_q]    = 1'b1;
      rsp_rdata_d[id_q]    = mem_data_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lock_vld_q  <= 1'b0;
      lock_id_q   <= 1'b0;
      hold_q      <= '0;
      last_q      <= REQ_LOAD;  // core wins the first tie
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lock_vld_q  <= lock_vld_d;
      lock_id_q   <= lock_id_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-level model checked
// every negedge, plus directed transfers with literal expectations.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MH = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req0_we, req0_lock;
  logic [3:0]    req0_be;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we, req1_lock;
  logic [3:0]    req1_be;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid, mem_memw;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata, mem_data_write, mem_data_read;
  logic [AW-1:0] mem_address;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_be(req0_be),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_be(req1_be),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_memw(mem_memw), .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read)
  );

  // Environment memory (what the DUT really talks to).
  logic [31:0] env_mem [0:255];
  assign mem_data_read = env_mem[mem_address[9:2]];
  always @(posedge clk) if (mem_memw) env_mem[mem_address[9:2]] <= mem_data_write;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [0:255];
  int          m_phase, m_last, m_hold, m_lock, m_pend;
  logic [31:0] m_rdata [2];
  int          c_id;
  logic        c_we;
  logic [3:0]  c_be;
  logic [31:0] c_addr, c_wdata;
  int          glog [$];

  always @(negedge clk) begin
    logic [1:0]  v;
    logic [31:0] word, mrg, byt;
    int          win;
    logic        lk;
    if (!rst_n) begin
      m_phase = 0; m_last = 1; m_hold = 0; m_lock = -1; m_pend = -1;
      m_rdata[0] = 0; m_rdata[1] = 0;
      c_id = 0; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_memw", mem_memw, 0);
      chk("rst_mem_address", mem_address, 0);
    end else begin
      chk("m_rsp0_valid", rsp0_valid, m_pend == 0);
      chk("m_rsp1_valid", rsp1_valid, m_pend == 1);
      chk("m_rsp0_rdata", rsp0_rdata, m_rdata[0]);
      chk("m_rsp1_rdata", rsp1_rdata, m_rdata[1]);
      m_pend = -1;
      if (m_phase == 1) begin
        word = ref_mem[c_addr[9:2]];
        mrg  = 0;
        for (int k = 0; k < 4; k++) begin
          byt = c_be[k] ? ((c_wdata >> (8*k)) & 32'hFF) : ((word >> (8*k)) & 32'hFF);
          mrg = mrg | (byt << (8*k));
        end
        chk("m_ready0_access", req0_ready, 0);
        chk("m_ready1_access", req1_ready, 0);
        chk("m_memw", mem_memw, c_we && (c_be != 0));
        chk("m_mem_address", mem_address, c_addr & 32'hFFFF_FFFC);
        chk("m_mem_data_write", mem_data_write, mrg);
        if (c_we && c_be != 0) ref_mem[c_addr[9:2]] = mrg;
        m_rdata[c_id] = word;
        m_pend  = c_id;
        m_phase = 0;
      end else begin
        chk("m_memw_idle", mem_memw, 0);
        chk("m_mem_address_idle", mem_address, c_addr & 32'hFFFF_FFFC);
        chk("m_mem_data_write_idle", mem_data_write, c_wdata);
        v = {req1_valid, req0_valid};
        if (m_lock >= 0 && !v[m_lock]) m_lock = -1;
        if (m_lock >= 0) begin
          if (m_hold >= MH && v[1-m_lock]) win = 1 - m_lock;
          else                             win = m_lock;
        end else if (v == 2'b11) win = 1 - m_last;
        else if (v[0])           win = 0;
        else if (v[1])           win = 1;
        else                     win = -1;
        chk("m_ready0", req0_ready, win == 0);
        chk("m_ready1", req1_ready, win == 1);
        if (win >= 0) begin
          glog.push_back(win);
          c_id    = win;
          c_we    = win ? req1_we : req0_we;
          c_be    = win ? req1_be : req0_be;
          c_addr  = win ? req1_addr : req0_addr;
          c_wdata = win ? req1_wdata : req0_wdata;
          lk      = win ? req1_lock : req0_lock;
          m_hold  = (win == m_last) ? ((m_hold < MH) ? m_hold + 1 : MH) : 1;
          m_last  = win;
          m_lock  = lk ? win : -1;
          m_phase = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    env_mem[a[9:2]] <= d;
    ref_mem[a[9:2]] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete();
  endtask

  task automatic drive(input int p, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = 1; req0_we = we; req0_be = be; req0_addr = a; req0_wdata = wd; req0_lock = 0;
    end else begin
      req1_valid = 1; req1_we = we; req1_be = be; req1_addr = a; req1_wdata = wd; req1_lock = 0;
    end
  endtask

  task automatic wait_accept(input int p);
    logic got;
    int   n;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = (p == 0) ? req0_ready : req1_ready;
      n++;
    end
    chk("accept_within_bound", got, 1);
  endtask

  task automatic do_xfer(input int p, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_memw, input logic [31:0] e_addr,
                         input logic [31:0] e_wd, input logic [31:0] e_rd);
    @(posedge clk); #1;
    drive(p, we, be, a, wd);
    wait_accept(p);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("lit_memw", mem_memw, e_memw);
    chk("lit_mem_address", mem_address, e_addr);
    chk("lit_mem_data_write", mem_data_write, e_wd);
    @(negedge clk);
    chk("lit_rsp_valid", (p == 0) ? rsp0_valid : rsp1_valid, 1);
    chk("lit_rsp_rdata", (p == 0) ? rsp0_rdata : rsp1_rdata, e_rd);
  endtask

  initial begin
    int lock_exp [10];
    req0_valid = 0; req0_we = 0; req0_be = 0; req0_addr = 0; req0_wdata = 0; req0_lock = 0;
    req1_valid = 0; req1_we = 0; req1_be = 0; req1_addr = 0; req1_wdata = 0; req1_lock = 0;
    for (int i = 0; i < 256; i++) begin env_mem[i] <= 0; ref_mem[i] = 0; end
    #1;
    chk("lit_reset_ready0", req0_ready, 0);
    chk("lit_reset_memw", mem_memw, 0);
    chk("lit_reset_addr", mem_address, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete();

    // Alternation: both valid, no lock, from reset.
    do_reset();
    @(posedge clk); #1;
    drive(0, 0, 4'h0, 32'h100, 0);
    drive(1, 0, 4'h0, 32'h104, 0);
    repeat (8) @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    repeat (3) @(posedge clk);
    chk("alt_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("alt_grant", glog[i], i % 2);

    // Burst lock with starvation bound.
    do_reset();
    @(posedge clk); #1;
    drive(0, 0, 4'h0, 32'h100, 0);
    drive(1, 0, 4'h0, 32'h104, 0);
    req0_lock = 1;
    repeat (20) @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0; req0_lock = 0;
    repeat (3) @(posedge clk);
    lock_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    chk("lock_count", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++) chk("lock_grant", glog[i], lock_exp[i]);

    // Full-word store then load back.
    do_xfer(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 1, 32'h10, 32'hDEADBEEF, 32'h0);
    do_xfer(0, 0, 4'h0, 32'h10, 32'h0, 0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);

    // Partial store via read-merge-write.
    @(posedge clk); #1 poke(32'h20, 32'h11223344);
    do_xfer(1, 1, 4'b0010, 32'h20, 32'h0000AA00, 1, 32'h20, 32'h1122AA44, 32'h11223344);
    do_xfer(1, 0, 4'h0, 32'h20, 32'h0, 0, 32'h20, 32'h1122AA44, 32'h1122AA44);

    // Store with no byte enables, unaligned address.
    @(posedge clk); #1 poke(32'h30, 32'h55);
    do_xfer(0, 1, 4'h0, 32'h33, 32'hFFFFFFFF, 0, 32'h30, 32'h55, 32'h55);
    chk("be0_mem_unchanged", env_mem[12], 32'h55);

    // Reset during the ACCESS cycle of a store.
    @(posedge clk); #1 poke(32'h40, 32'h77);
    @(posedge clk); #1;
    drive(0, 1, 4'hF, 32'h40, 32'hCAFEF00D);
    wait_accept(0);
    @(posedge clk); #1 req0_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_memw", mem_memw, 0);
    chk("arst_mem_address", mem_address, 0);
    chk("arst_mem_data_write", mem_data_write, 0);
    chk("arst_rsp0_valid", rsp0_valid, 0);
    chk("arst_rsp0_rdata", rsp0_rdata, 0);
    chk("arst_rsp1_rdata", rsp1_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_mem_untouched", env_mem[16], 32'h77);
    do_xfer(1, 0, 4'h0, 32'h40, 32'h0, 0, 32'h40, 32'h77, 32'h77);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port word-wide data memory between two requesters: requester 0 (core load/store unit) and requester 1 (program/debug loader). Provides valid/ready request handshakes, round-robin arbitration with optional burst lock and a starvation bound, byte-enable partial stores via read-merge-write, and a registered read response. It sits between the requesters and the data memory, driving its write enable, address and write data, and sampling its combinational read data.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; fixed 4 byte lanes
MAX_HOLD, 8, max consecutive grants to one requester while the other waits (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
req0_we / req1_we  in  1  1=store, 0=load
req0_be / req1_be  in  4  byte enables (store only)
req0_addr / req1_addr  in  ADDR_W  byte address
req0_wdata / req1_wdata  in  DATA_W  store data, lane-aligned
req0_lock / req1_lock  in  1  keep grant for next transfer
rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
rsp0_rdata / rsp1_rdata  out  DATA_W  memory word read (pre-write contents)
mem_memw  out  1  data memory write enable
mem_address  out  ADDR_W  data memory address, word aligned
mem_data_write  out  DATA_W  merged store word
mem_data_read  in  DATA_W  data memory combinational read

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all ready, rsp_valid, mem_memw = 0; rsp_rdata = 0; captured addr/data/be/we/id = 0 (so mem_address=0); lock_owner none; hold_cnt=0; last_grant=1 (core wins first tie). An ACCESS in flight when reset asserts is dropped; no write occurs.
- FSM: IDLE -> ACCESS on accept; ACCESS -> IDLE unconditionally. At most one ready per cycle, only in IDLE. ready is combinational from valids and arbitration state.
- Accept in cycle T: capture id, we, be, addr, wdata. T+1 (ACCESS): mem_address={addr[ADDR_W-1:2],2'b00}; addr[1:0] ignored. mem_memw = we & (be!=0). mem_data_write lane k = be[k] ? wdata lane k : mem_data_read lane k. mem_data_read is registered into rsp_rdata of the captured id. T+2: rsp<id>_valid=1 for exactly one cycle, rdata held until next response to that id. New accept may occur in T+2. Throughput is 1 transfer per 2 cycles.
- Outside ACCESS, mem_memw=0 and mem_data_write=captured wdata.
- Arbitration in IDLE:
  - One valid: that requester wins, subject to lock rules.
  - Both valid, no lock: winner is !last_grant.
  - Lock: lock_owner is set when an accepted transfer has lock=1. It is cleared when the owner's accepted transfer has lock=0, when the owner is not valid in an IDLE cycle, or on a forced switch.
  - While locked, the owner wins if valid, unless hold_cnt==MAX_HOLD and the other requester is valid. In that case the other wins (forced switch) and the lock clears.
  - A non-owner is never granted while the owner is valid and hold_cnt<MAX_HOLD.
- hold_cnt: on accept, hold_cnt = (winner==last_grant) ? sat(hold_cnt+1) : 1; last_grant=winner.
- Store with we=1, be=0: no write; a response is still returned.
- Load (we=0): be ignored; mem_memw=0.

Decomposition:
- dmem_pkg: state enum {IDLE, ACCESS}; constants REQ_CORE=0 and REQ_LOAD=1; byte-lane merge function (wdata, rdata, be); NUM_LANES=4.
- One sub-module, dmem_rr_picker: combinational winner/ready selection from valids, last_grant, lock_owner, hold_cnt and MAX_HOLD. The FSM, capture registers and response registers live in dmem_arbiter.

Test Plan:
- Reset then req0 store addr=0x10, be=1111, wdata=0xDEADBEEF. Expect: ready0 in T; mem_memw=1 with mem_address=0x10 in T+1; rsp0_valid in T+2. Then a load at 0x10 returns 0xDEADBEEF.
- Word 0x20=0x11223344; req1 store be=0010, wdata=0x0000AA00. Expect: mem_data_write=0x1122AA44; rsp1_rdata=0x11223344; a later load returns 0x1122AA44.
- Both valid continuously, no lock, from reset. Expect grants alternate 0,1,0,1, one accept every 2 cycles.
- req0 lock=1 continuously, req1 valid, MAX_HOLD=8. Expect 8 consecutive grants to req0, then req1 granted; lock cleared.
- Store with be=0000 to 0x30 holding 0x55. Expect mem_memw=0, memory unchanged, rsp_valid pulse with rdata=0x55. Also: addr=0x33 maps to mem_address=0x30.
- rst_n asserted during ACCESS of a store. Expect no memory write, no rsp_valid, and all outputs 0 immediately (asynchronous).
